latch_wr_seq: RTL and testbench

Write sequencer that loads a bank of level-sensitive D latches (`d_latch` cells) from a clocked valid/ready write port. For each accepted write it runs the latch-safe sequence: data set up with every enable low, one enable pulsed, data held after the enable falls. It sits directly upstream of the latch bank and is the only driver of the bank's shared D bus and per-latch enables. The sequence guarantees that no latch is transparent while its D input changes.

---
 rtl/latch_wr_seq.sv | 127 ++++++++++++
 tb/tb_latch_wr_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_wr_seq.sv
// Write sequencer for a bank of level-sensitive D latches: each accepted write
// sets up the shared D bus, pulses one enable, then holds D before taking the next.
module latch_wr_seq #(
  parameter int unsigned DW    = 8,
  parameter int unsigned NUM   = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned SETUP = 1,
  parameter int unsigned PULSE = 2,
  parameter int unsigned HOLD  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_addr,
  input  logic [DW-1:0]     in_data,
  output logic [DW-1:0]     lat_d,
  output logic [NUM-1:0]    lat_en,
  output logic              busy,
  output logic              err,
  output logic [15:0]       wr_cnt
);

  localparam int unsigned MAX_SP = (SETUP > PULSE) ? SETUP : PULSE;
  localparam int unsigned MAX_C  = (MAX_SP > HOLD) ? MAX_SP : HOLD;
  localparam int unsigned CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [AW-1:0]   addr, addr_nxt;
  logic [DW-1:0]   lat_d_nxt;
  logic [NUM-1:0]  lat_en_nxt;
  logic            err_nxt;
  logic            wr_done;
  logic            addr_ok;

  assign addr_ok = (32'(in_addr) < NUM);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      addr     <= '0;
      lat_d    <= '0;
      lat_en   <= '0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      err      <= 1'b0;
      wr_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      addr     <= addr_nxt;
      lat_d    <= lat_d_nxt;
      lat_en   <= lat_en_nxt;
      in_ready <= (state_nxt == ST_IDLE);
      busy     <= (state_nxt != ST_IDLE);
      err      <= err_nxt;
      wr_cnt   <= wr_cnt + 16'(wr_done);
    end
  end

  // Next-state, counter and next-output decode
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    addr_nxt   = addr;
    lat_d_nxt  = lat_d;
    lat_en_nxt = '0;
    err_nxt    = 1'b0;
    wr_done    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (addr_ok) begin
            addr_nxt  = in_addr;
            lat_d_nxt = in_data;
            cnt_nxt   = CW'(SETUP - 1);
            state_nxt = ST_SETUP;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          cnt_nxt   = CW'(PULSE - 1);
          state_nxt = ST_PULSE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          cnt_nxt   = CW'(HOLD - 1);
          state_nxt = ST_HOLD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          wr_done   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Enable is a pure function of the next state so it can never overlap a D change
    if (state_nxt == ST_PULSE) begin
      lat_en_nxt = NUM'(1) << addr_nxt;
    end
  end

endmodule

// File: tb/tb_latch_wr_seq.sv
// Bench for latch_wr_seq: default instance plus a NUM=3, SETUP=2/PULSE=1/HOLD=3
// instance on shared stimulus, both checked against a timeline model and latch models.
module tb_latch_wr_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_addr = '0;
  logic [7:0] in_data = '0;

  logic       rdy0, busy0, err0, rdy1, busy1, err1;
  logic [7:0] d0, d1;
  logic [3:0] en0;
  logic [2:0] en1;
  logic [15:0] wc0, wc1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  latch_wr_seq u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_addr(in_addr), .in_data(in_data), .lat_d(d0), .lat_en(en0),
    .busy(busy0), .err(err0), .wr_cnt(wc0)
  );

  latch_wr_seq #(.DW(8), .NUM(3), .AW(2), .SETUP(2), .PULSE(1), .HOLD(3)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_addr(in_addr), .in_data(in_data), .lat_d(d1), .lat_en(en1),
    .busy(busy1), .err(err1), .wr_cnt(wc1)
  );

  // Reference model: time since acceptance decides every output
  logic        m_ready [2];
  int          m_t     [2];
  logic [1:0]  m_addr  [2];
  logic [7:0]  m_d     [2];
  logic        m_err   [2];
  logic [15:0] m_cnt   [2];
  logic [7:0]  m_mem   [2][4];
  logic [7:0]  lat     [2][4];
  logic [7:0]  pd      [2];
  logic [3:0]  pe      [2];
  logic        have_prev = 1'b0;

  function automatic int nw(int k); return (k == 0) ? 4 : 3; endfunction
  function automatic int sp(int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int pl(int k); return (k == 0) ? 2 : 1; endfunction
  function automatic int hd(int k); return (k == 0) ? 1 : 3; endfunction

  function automatic logic [3:0] exp_en(int k);
    logic [3:0] one;
    one = 4'b0001;
    if (!m_ready[k] && m_t[k] >= sp(k) && m_t[k] < sp(k) + pl(k))
      return one << m_addr[k];
    return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [1:0] a, input logic [7:0] dv);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_ready[k] = 1'b1; m_t[k] = 0; m_d[k] = '0; m_err[k] = 1'b0; m_cnt[k] = '0;
      end else if (m_ready[k]) begin
        m_err[k] = 1'b0;
        if (v) begin
          if (int'(a) < nw(k)) begin
            m_ready[k] = 1'b0; m_t[k] = 0; m_addr[k] = a; m_d[k] = dv;
          end else begin
            m_err[k] = 1'b1;
          end
        end
      end else begin
        m_err[k] = 1'b0;
        m_t[k]++;
        if (m_t[k] == sp(k)) m_mem[k][m_addr[k]] = m_d[k];
        if (m_t[k] == sp(k) + pl(k) + hd(k)) begin
          m_ready[k] = 1'b1;
          m_cnt[k]   = m_cnt[k] + 16'd1;
        end
      end
    end
  endtask

  task automatic cmp(input int k, input logic rdy, input logic bsy, input logic er,
                     input logic [7:0] d, input logic [3:0] en, input logic [15:0] wc,
                     input logic r);
    chk($sformatf("ready%0d", k), 32'(rdy), 32'(m_ready[k]));
    chk($sformatf("busy%0d", k), 32'(bsy), 32'(!m_ready[k]));
    chk($sformatf("err%0d", k), 32'(er), 32'(m_err[k]));
    chk($sformatf("lat_d%0d", k), 32'(d), 32'(m_d[k]));
    chk($sformatf("lat_en%0d", k), 32'(en), 32'(exp_en(k)));
    chk($sformatf("wr_cnt%0d", k), 32'(wc), 32'(m_cnt[k]));
    for (int i = 0; i < nw(k); i++) begin
      if (en[i] === 1'b1) lat[k][i] = d;
      chk($sformatf("latch%0d_%0d", k, i), 32'(lat[k][i]), 32'(m_mem[k][i]));
    end
    if (!r && have_prev)
      chk($sformatf("d_while_en%0d", k), 32'((d !== pd[k]) && ((en | pe[k]) != 4'b0)), 32'(0));
    pd[k] = d;
    pe[k] = en;
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] a, input logic [7:0] dv);
    rst = r; in_valid = v; in_addr = a; in_data = dv;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(r, v, a, dv);
    cmp(0, rdy0, busy0, err0, d0, en0, wc0, r);
    cmp(1, rdy1, busy1, err1, d1, {1'b0, en1}, wc1, r);
    have_prev = 1'b1;
  endtask

  task automatic drain();
    for (int g = 0; g < 20 && !(rdy0 && rdy1); g++) step(1'b0, 1'b0, 2'd0, 8'd0);
    chk("drain", 32'({rdy0, rdy1}), 32'(2'b11));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 2'd0, 8'd0);
    step(1'b1, 1'b1, 2'd1, 8'hEE);
  endtask

  initial begin
    int acc[3];
    logic [1:0] ba[3];
    logic [7:0] bd[3];
    logic accepted, was;

    for (int k = 0; k < 2; k++) begin
      m_ready[k] = 1'b1; m_t[k] = 0; m_addr[k] = '0; m_d[k] = '0;
      m_err[k] = 1'b0; m_cnt[k] = '0; pd[k] = '0; pe[k] = '0;
      for (int i = 0; i < 4; i++) begin m_mem[k][i] = '0; lat[k][i] = '0; end
    end

    // Reset state, then single write addr=2 data=A5
    do_reset();
    chk("rst_ready", 32'(rdy0), 32'(1));
    chk("rst_wrcnt", 32'(wc0), 32'(0));
    step(1'b0, 1'b1, 2'd2, 8'hA5);
    chk("w1_lat_d", 32'(d0), 32'hA5);
    step(1'b0, 1'b0, 2'd0, 8'd0);
    chk("w1_en_a", 32'(en0), 32'(4'b0100));
    step(1'b0, 1'b0, 2'd0, 8'd0);
    chk("w1_en_b", 32'(en0), 32'(4'b0100));
    step(1'b0, 1'b0, 2'd0, 8'd0);
    chk("w1_en_off", 32'(en0), 32'(0));
    step(1'b0, 1'b0, 2'd0, 8'd0);
    chk("w1_ready", 32'(rdy0), 32'(1));
    chk("w1_wrcnt", 32'(wc0), 32'(1));
    chk("w1_latch2", 32'(lat[0][2]), 32'hA5);
    drain();

    // Back-to-back writes with valid held high
    do_reset();
    ba = '{2'd0, 2'd1, 2'd3};
    bd = '{8'h11, 8'h22, 8'h44};
    for (int i = 0; i < 3; i++) begin
      accepted = 1'b0;
      acc[i] = 0;
      for (int g = 0; g < 20 && !accepted; g++) begin
        was = m_ready[0];
        step(1'b0, 1'b1, ba[i], bd[i]);
        if (was && !m_ready[0]) begin accepted = 1'b1; acc[i] = cyc; end
      end
      chk($sformatf("b2b_accept%0d", i), 32'(accepted), 32'(1));
    end
    chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'(5));
    chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'(5));
    drain();
    chk("b2b_wrcnt", 32'(wc0), 32'(3));

    // Out-of-range on the NUM=3 instance, then an immediate valid write
    drain();
    step(1'b0, 1'b1, 2'd3, 8'h33);
    chk("oor_err", 32'(err1), 32'(1));
    chk("oor_en", 32'(en1), 32'(0));
    chk("oor_ready", 32'(rdy1), 32'(1));
    step(1'b0, 1'b1, 2'd1, 8'h77);
    chk("oor_err_clr", 32'(err1), 32'(0));
    chk("oor_next_acc", 32'(rdy1), 32'(0));
    chk("oor_next_d", 32'(d1), 32'h77);
    drain();

    // Reset in the middle of a pulse
    step(1'b0, 1'b1, 2'd0, 8'h5A);
    for (int g = 0; g < 10 && en0 != 4'b0001; g++) step(1'b0, 1'b0, 2'd0, 8'd0);
    chk("rp_in_pulse", 32'(en0), 32'(4'b0001));
    step(1'b1, 1'b0, 2'd0, 8'd0);
    chk("rp_en", 32'(en0), 32'(0));
    chk("rp_ready", 32'(rdy0), 32'(1));
    chk("rp_wrcnt", 32'(wc0), 32'(0));
    chk("rp_latch0", 32'(lat[0][0]), 32'h5A);

    // Wrap of the completed-write counter
    drain();
    force u_d0.wr_cnt = 16'hFFFF;
    #1;
    release u_d0.wr_cnt;
    m_cnt[0] = 16'hFFFF;
    step(1'b0, 1'b1, 2'd3, 8'hC3);
    drain();
    chk("wrap", 32'(wc0), 32'(0));

    // Randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
           2'($urandom_range(0, 3)), 8'($urandom));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
